sn74_ls298: RTL and testbench

SN74_LS298 -- requirements
Module: sn74_ls298

---
 rtl/sn74_ls298.sv | 30 +++
 tb/tb_sn74_ls298.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sn74_ls298.sv
// 74LS298-style quad 2-port register: a WIDTH-bit 2:1 word mux feeding a
// falling-edge storage register with asynchronous active-high clear.
module sn74_ls298 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2,
    input  logic             ws,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_q;

    // An unknown ws resolves per bit: agreeing bits pass through, others go X.
    assign w_sel = ws ? s2 : s1;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_sel;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_sn74_ls298.sv
// Directed bench for sn74_ls298: table-driven word-select vectors plus
// hand-written sequences for hold, edge immunity and asynchronous clear.
module tb_sn74_ls298;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic         ws;
    logic [W-1:0] q;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic         ws;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl [6];

    sn74_ls298 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .s1  (s1),
        .s2  (s2),
        .ws  (ws),
        .q   (q)
    );

    // 100 ns half period; falling edges at 100, 300, 500 ...
    initial begin
        clk = 1'b1;
        forever #100 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: q=%b expected %b", nm, act, exp);
        end
    endtask

    // Drive inputs early in the high phase, well away from the falling edge.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic w);
        @(posedge clk);
        #10;
        s1 = a;
        s2 = b;
        ws = w;
    endtask

    task automatic after_fall();
        @(negedge clk);
        #1;
    endtask

    logic [W-1:0] prev;

    initial begin
        tbl[0] = '{4'b0110, 4'b1001, 1'b0, 4'b0110};
        tbl[1] = '{4'b0110, 4'b1001, 1'b1, 4'b1001};
        tbl[2] = '{4'b1010, 4'b0101, 1'b1, 4'b0101};
        tbl[3] = '{4'b1010, 4'b0101, 1'b0, 4'b1010};
        tbl[4] = '{4'b0000, 4'b1111, 1'b1, 4'b1111};
        tbl[5] = '{4'b0011, 4'b1111, 1'b0, 4'b0011};

        rst = 1'b1;
        s1  = 4'b0110;
        s2  = 4'b1001;
        ws  = 1'b0;

        // Reset holds q at zero across falling edges.
        after_fall();
        chk("reset_state", q, 4'b0000);
        after_fall();
        chk("reset_over_edge", q, 4'b0000);

        // Release just after a falling edge: nothing loads until the next one.
        #5;
        rst = 1'b0;
        #1;
        chk("release_hold", q, 4'b0000);
        @(posedge clk);
        #1;
        chk("release_rise", q, 4'b0000);
        after_fall();
        chk("first_load", q, 4'b0110);

        // Table vectors; also confirm no combinational path before the edge.
        prev = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].s1, tbl[i].s2, tbl[i].ws);
            #20;
            chk($sformatf("vec%0d_pre", i), q, prev);
            after_fall();
            chk($sformatf("vec%0d", i), q, tbl[i].exp);
            prev = tbl[i].exp;
        end

        // Hold between edges: s1 change in both phases has no effect until a fall.
        drive(4'b0110, 4'b1001, 1'b0);
        after_fall();
        chk("hold_load", q, 4'b0110);
        #20;
        s1 = 4'b1111;
        #20;
        chk("hold_low_phase", q, 4'b0110);
        @(posedge clk);
        #30;
        chk("hold_high_phase", q, 4'b0110);
        after_fall();
        chk("hold_next_fall", q, 4'b1111);

        // Rising-edge immunity: ws set in the low phase, crossing a rising edge.
        #20;
        s1 = 4'b0110;
        s2 = 4'b1001;
        ws = 1'b1;
        @(posedge clk);
        #1;
        chk("rise_immune", q, 4'b1111);
        after_fall();
        chk("rise_then_fall", q, 4'b1001);

        // Asynchronous clear mid high phase, release with ws=0, then load.
        @(posedge clk);
        #20;
        rst = 1'b1;
        #1;
        chk("async_clear", q, 4'b0000);
        #20;
        ws  = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_release", q, 4'b0000);
        after_fall();
        chk("async_reload", q, 4'b0110);

        // Select sweep: 8 loads with ws=0, then ws=1.
        s1 = 4'b0110;
        s2 = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            after_fall();
            chk($sformatf("sweep_ws0_%0d", i), q, 4'b0110);
        end
        #20;
        ws = 1'b1;
        after_fall();
        chk("sweep_ws1", q, 4'b1001);
        after_fall();
        chk("sweep_ws1_hold", q, 4'b1001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
